// File: rtl/eng_pipe_pkg.sv
// Shared engine-pipe types: ROM PC type and fetch-agent FSM states.
package eng_pipe_pkg;

    localparam int unsigned ROM_PC_W = 8;

    typedef logic [ROM_PC_W-1:0] rom_pc_t;

    typedef enum logic [1:0] {
        FA_IDLE  = 2'd0,
        FA_RUN   = 2'd1,
        FA_ABORT = 2'd2
    } fa_state_t;

endpackage

// File: rtl/eng_pipe_fa_wdog.sv
// Saturating per-microprogram issue counter with limit flag.
module eng_pipe_fa_wdog #(
    parameter int unsigned STEP_MAX = 255
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int unsigned CNT_W = (STEP_MAX < 1) ? 1 : $clog2(STEP_MAX + 1);

    logic [CNT_W-1:0] cnt;

    // clr restarts the count; clr together with inc counts the first issue
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_max = (cnt >= CNT_W'(STEP_MAX));

endmodule

// File: rtl/eng_pipe_fa.sv
// Fetch agent: sequences microcode PCs to XA, handles stall/redirect/done,
// and aborts on PC wrap or watchdog exhaustion.
module eng_pipe_fa
    import eng_pipe_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned STEP_MAX = 255
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            i_cmd_vld,
    input  logic [PC_W-1:0] i_cmd_pc,
    output logic            o_cmd_rdy,
    output logic            o_fa_vld_r,
    output logic [PC_W-1:0] o_fa_pc_r,
    input  logic            i_xa_stall,
    input  logic            i_xa_redirect_vld,
    input  logic [PC_W-1:0] i_xa_redirect_pc,
    input  logic            i_xa_done,
    output logic            o_busy_r,
    output logic            o_err_r
);

    fa_state_t state;
    logic      wd_clr;
    logic      wd_inc;
    logic      at_max;
    logic      pc_last;

    assign pc_last   = &o_fa_pc_r;
    assign o_cmd_rdy = (state == FA_IDLE);

    // Watchdog control: count every issued PC, restart on new or finished program
    always_comb begin
        wd_clr = 1'b0;
        wd_inc = 1'b0;
        case (state)
            FA_IDLE: begin
                if (i_cmd_vld) begin
                    wd_clr = 1'b1;
                    wd_inc = 1'b1;
                end
            end
            FA_RUN: begin
                if (i_xa_done) begin
                    wd_clr = 1'b1;
                end else if (i_xa_redirect_vld) begin
                    wd_inc = !at_max;
                end else if (!i_xa_stall) begin
                    wd_inc = !at_max && !pc_last;
                end
            end
            FA_ABORT: wd_clr = 1'b1;
            default:  wd_clr = 1'b1;
        endcase
    end

    eng_pipe_fa_wdog #(
        .STEP_MAX (STEP_MAX)
    ) u_wdog (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (wd_clr),
        .inc    (wd_inc),
        .at_max (at_max)
    );

    // FSM with registered fetch, busy and error outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= FA_IDLE;
            o_fa_vld_r <= 1'b0;
            o_fa_pc_r  <= '0;
            o_busy_r   <= 1'b0;
            o_err_r    <= 1'b0;
        end else begin
            o_err_r <= 1'b0;
            case (state)
                FA_IDLE: begin
                    if (i_cmd_vld) begin
                        state      <= FA_RUN;
                        o_fa_pc_r  <= i_cmd_pc;
                        o_fa_vld_r <= 1'b1;
                        o_busy_r   <= 1'b1;
                    end
                end
                FA_RUN: begin
                    if (i_xa_done) begin
                        state      <= FA_IDLE;
                        o_fa_vld_r <= 1'b0;
                        o_busy_r   <= 1'b0;
                    end else if (i_xa_redirect_vld) begin
                        if (at_max) begin
                            state      <= FA_ABORT;
                            o_fa_vld_r <= 1'b0;
                            o_err_r    <= 1'b1;
                        end else begin
                            o_fa_pc_r  <= i_xa_redirect_pc;
                            o_fa_vld_r <= 1'b1;
                        end
                    end else if (!i_xa_stall) begin
                        if (at_max || pc_last) begin
                            state      <= FA_ABORT;
                            o_fa_vld_r <= 1'b0;
                            o_err_r    <= 1'b1;
                        end else begin
                            o_fa_pc_r <= o_fa_pc_r + PC_W'(1);
                        end
                    end
                end
                FA_ABORT: begin
                    state      <= FA_IDLE;
                    o_fa_vld_r <= 1'b0;
                    o_busy_r   <= 1'b0;
                end
                default: begin
                    state      <= FA_IDLE;
                    o_fa_vld_r <= 1'b0;
                    o_busy_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eng_pipe_fa.sv
// Directed bench for eng_pipe_fa: vector table plus reset and watchdog sequences.
module tb_eng_pipe_fa;

    logic       clk;
    logic       arst_n;
    logic       cmd_vld;
    logic [7:0] cmd_pc;
    logic       xa_stall;
    logic       xa_redirect_vld;
    logic [7:0] xa_redirect_pc;
    logic       xa_done;

    logic       cmd_rdy,  fa_vld,  busy,  err;
    logic [7:0] fa_pc;
    logic       cmd_rdy4, fa_vld4, busy4, err4;
    logic [7:0] fa_pc4;

    int n_chk  = 0;
    int n_fail = 0;

    eng_pipe_fa #(.PC_W(8), .STEP_MAX(255)) dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .i_cmd_vld         (cmd_vld),
        .i_cmd_pc          (cmd_pc),
        .o_cmd_rdy         (cmd_rdy),
        .o_fa_vld_r        (fa_vld),
        .o_fa_pc_r         (fa_pc),
        .i_xa_stall        (xa_stall),
        .i_xa_redirect_vld (xa_redirect_vld),
        .i_xa_redirect_pc  (xa_redirect_pc),
        .i_xa_done         (xa_done),
        .o_busy_r          (busy),
        .o_err_r           (err)
    );

    eng_pipe_fa #(.PC_W(8), .STEP_MAX(4)) dut4 (
        .clk               (clk),
        .arst_n            (arst_n),
        .i_cmd_vld         (cmd_vld),
        .i_cmd_pc          (cmd_pc),
        .o_cmd_rdy         (cmd_rdy4),
        .o_fa_vld_r        (fa_vld4),
        .o_fa_pc_r         (fa_pc4),
        .i_xa_stall        (xa_stall),
        .i_xa_redirect_vld (xa_redirect_vld),
        .i_xa_redirect_pc  (xa_redirect_pc),
        .i_xa_done         (xa_done),
        .o_busy_r          (busy4),
        .o_err_r           (err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       cv;
        logic [7:0] cpc;
        logic       st;
        logic       rv;
        logic [7:0] rpc;
        logic       dn;
        logic       ev;
        logic [7:0] epc;
        logic       eb;
        logic       ee;
        logic       er;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(logic cv, logic [7:0] cpc, logic st, logic rv,
                                logic [7:0] rpc, logic dn, logic ev, logic [7:0] epc,
                                logic eb, logic ee, logic er);
        vec_t v;
        v.cv = cv; v.cpc = cpc; v.st = st; v.rv = rv; v.rpc = rpc; v.dn = dn;
        v.ev = ev; v.epc = epc; v.eb = eb; v.ee = ee; v.er = er;
        return v;
    endfunction

    // Tuple order: {vld, pc, busy, err, rdy}
    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got vld,pc,busy,err,rdy=%h required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic cv, input logic [7:0] cpc, input logic st,
                         input logic rv, input logic [7:0] rpc, input logic dn);
        cmd_vld = cv; cmd_pc = cpc; xa_stall = st;
        xa_redirect_vld = rv; xa_redirect_pc = rpc; xa_done = dn;
    endtask

    // Pulse reset mid-cycle, check both DUTs cleared, release before next edge
    task automatic do_reset(input string name);
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        @(posedge clk);
        #1 arst_n = 1'b0;
        #1;
        chk({name, "_dut"},  {fa_vld,  fa_pc,  busy,  err,  cmd_rdy},  {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        chk({name, "_dut4"}, {fa_vld4, fa_pc4, busy4, err4, cmd_rdy4}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        #3 arst_n = 1'b1;
    endtask

    initial begin
        arst_n = 1'b1;
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        #1 arst_n = 1'b0;
        #1;
        chk("por_reset", {fa_vld, fa_pc, busy, err, cmd_rdy}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});

        //           cv cpc    st rv rpc    dn  ev epc    eb ee er
        tbl[0]  = mk(1, 8'h10, 0, 0, 8'h00, 0,  1, 8'h10, 1, 0, 0);
        tbl[1]  = mk(0, 8'h00, 0, 0, 8'h00, 0,  1, 8'h11, 1, 0, 0);
        tbl[2]  = mk(0, 8'h00, 0, 0, 8'h00, 0,  1, 8'h12, 1, 0, 0);
        tbl[3]  = mk(0, 8'h00, 0, 0, 8'h00, 0,  1, 8'h13, 1, 0, 0);
        tbl[4]  = mk(0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h13, 0, 0, 1);
        tbl[5]  = mk(1, 8'h20, 0, 0, 8'h00, 0,  1, 8'h20, 1, 0, 0);
        tbl[6]  = mk(0, 8'h00, 1, 0, 8'h00, 0,  1, 8'h20, 1, 0, 0);
        tbl[7]  = mk(0, 8'h00, 1, 0, 8'h00, 0,  1, 8'h20, 1, 0, 0);
        tbl[8]  = mk(0, 8'h00, 1, 0, 8'h00, 0,  1, 8'h20, 1, 0, 0);
        tbl[9]  = mk(0, 8'h00, 0, 0, 8'h00, 0,  1, 8'h21, 1, 0, 0);
        tbl[10] = mk(0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h21, 0, 0, 1);
        tbl[11] = mk(1, 8'h30, 0, 0, 8'h00, 0,  1, 8'h30, 1, 0, 0);
        tbl[12] = mk(0, 8'h00, 1, 1, 8'h80, 0,  1, 8'h80, 1, 0, 0);
        tbl[13] = mk(0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h80, 0, 0, 1);
        tbl[14] = mk(1, 8'hFE, 0, 0, 8'h00, 0,  1, 8'hFE, 1, 0, 0);
        tbl[15] = mk(0, 8'h00, 0, 0, 8'h00, 0,  1, 8'hFF, 1, 0, 0);
        tbl[16] = mk(0, 8'h00, 0, 0, 8'h00, 0,  0, 8'hFF, 1, 1, 0);
        tbl[17] = mk(0, 8'h00, 0, 0, 8'h00, 0,  0, 8'hFF, 0, 0, 1);
        tbl[18] = mk(0, 8'h00, 1, 1, 8'h77, 1,  0, 8'hFF, 0, 0, 1);
        tbl[19] = mk(1, 8'hFF, 0, 0, 8'h00, 0,  1, 8'hFF, 1, 0, 0);
        tbl[20] = mk(0, 8'h00, 0, 0, 8'h00, 1,  0, 8'hFF, 0, 0, 1);
        tbl[21] = mk(1, 8'h50, 0, 0, 8'h00, 0,  1, 8'h50, 1, 0, 0);
        tbl[22] = mk(0, 8'h00, 0, 1, 8'h90, 1,  0, 8'h50, 0, 0, 1);
        tbl[23] = mk(1, 8'h60, 0, 0, 8'h00, 0,  1, 8'h60, 1, 0, 0);
        tbl[24] = mk(1, 8'h70, 0, 0, 8'h00, 0,  1, 8'h61, 1, 0, 0);
        tbl[25] = mk(0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h61, 0, 0, 1);

        do_reset("reset_start");
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].cv, tbl[i].cpc, tbl[i].st, tbl[i].rv, tbl[i].rpc, tbl[i].dn);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), {fa_vld, fa_pc, busy, err, cmd_rdy},
                {tbl[i].ev, tbl[i].epc, tbl[i].eb, tbl[i].ee, tbl[i].er});
        end

        // Watchdog on STEP_MAX=4 instance: endless redirects to 0x00
        do_reset("reset_wdog");
        drive(1, 8'h00, 0, 1, 8'h00, 0);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) cmd_vld = 1'b0;
            chk($sformatf("wdog_c%0d", c), {fa_vld4, fa_pc4, busy4, err4, cmd_rdy4},
                {(c <= 4), 8'h00, (c <= 5), (c == 5), (c >= 6)});
        end
        drive(0, 8'h00, 0, 0, 8'h00, 0);

        // Asynchronous reset in the middle of a run at PC 0x45
        do_reset("reset_mid");
        drive(1, 8'h40, 0, 0, 8'h00, 0);
        @(posedge clk);
        #1 cmd_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_pc45", {fa_vld, fa_pc, busy, err, cmd_rdy}, {1'b1, 8'h45, 1'b1, 1'b0, 1'b0});
        #2 arst_n = 1'b0;
        #1;
        chk("mid_async", {fa_vld, fa_pc, busy, err, cmd_rdy}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        chk("mid_held", {fa_vld, fa_pc, busy, err, cmd_rdy}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        #2 arst_n = 1'b1;
        drive(1, 8'h12, 0, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        chk("mid_first_cmd", {fa_vld, fa_pc, busy, err, cmd_rdy}, {1'b1, 8'h12, 1'b1, 1'b0, 1'b0});
        drive(0, 8'h00, 0, 0, 8'h00, 1);
        @(posedge clk);
        #1;
        chk("mid_done", {fa_vld, fa_pc, busy, err, cmd_rdy}, {1'b0, 8'h12, 1'b0, 1'b0, 1'b1});
        drive(0, 8'h00, 0, 0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/eng_pipe_fa.md
ENG_PIPE_FA -- requirements
Module: eng_pipe_fa

Interface
REQ-001 Parameter PC_W, default 8, microcode PC width in bits (rom_pc_t).
REQ-002 Parameter STEP_MAX, default 255, maximum instructions issued per microprogram before watchdog abort.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port arst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port i_cmd_vld  input  1  new microprogram request.
REQ-006 Port i_cmd_pc  input  PC_W  microprogram entry PC.
REQ-007 Port o_cmd_rdy  output  1  request accepted this cycle when high with i_cmd_vld.
REQ-008 Port o_fa_vld_r  output  1  registered: o_fa_pc_r is a live fetch for XA.
REQ-009 Port o_fa_pc_r  output  PC_W  registered fetch PC driven to XA ROM.
REQ-010 Port i_xa_stall  input  1  XA cannot consume; FA SHALL hold.
REQ-011 Port i_xa_redirect_vld  input  1  XA branch taken.
REQ-012 Port i_xa_redirect_pc  input  PC_W  branch target.
REQ-013 Port i_xa_done  input  1  XA retired END instruction.
REQ-014 Port o_busy_r  output  1  registered, high in any state except IDLE.
REQ-015 Port o_err_r  output  1  registered one-cycle pulse on watchdog or PC-wrap abort.

Function
REQ-016 FSM states IDLE, RUN, ABORT; one-hot or binary encoding left to implementer.
REQ-017 o_cmd_rdy SHALL be combinationally high only in IDLE.
REQ-018 IDLE & i_cmd_vld: next cycle state RUN, o_fa_pc_r=i_cmd_pc, o_fa_vld_r=1, step count=1.
REQ-019 RUN priority per cycle: i_xa_done > i_xa_redirect_vld > i_xa_stall > increment.
REQ-020 RUN & i_xa_done: next cycle state IDLE, o_fa_vld_r=0, o_fa_pc_r holds value.
REQ-021 RUN & redirect (no done): next cycle o_fa_pc_r=i_xa_redirect_pc, o_fa_vld_r=1, step count+1; redirect honoured even when i_xa_stall=1.
REQ-022 RUN & stall only: o_fa_pc_r, o_fa_vld_r, step count unchanged.
REQ-023 RUN otherwise: o_fa_pc_r+1 modulo 2^PC_W, step count+1.
REQ-024 Increment from PC=2^PC_W-1 (wrap) SHALL enter ABORT instead of issuing PC 0.
REQ-025 Step count reaching STEP_MAX with a further advance (redirect or increment) SHALL enter ABORT.
REQ-026 ABORT lasts exactly one cycle: o_fa_vld_r=0, o_err_r=1, then IDLE; o_cmd_rdy low in ABORT.
REQ-027 i_xa_done in same cycle as wrap or watchdog condition: done wins, no error.
REQ-028 Step counter width clog2(STEP_MAX+1); saturates, never wraps.
REQ-029 Redirect/stall/done inputs SHALL be ignored in IDLE and ABORT.

Reset
REQ-030 Asynchronous assertion of arst_n SHALL force state IDLE, o_fa_vld_r=0, o_fa_pc_r=0, o_busy_r=0, o_err_r=0, step count=0, irrespective of clk.
REQ-031 Reset mid-RUN discards the in-flight microprogram; no o_err_r pulse.
REQ-032 First command SHALL be acceptable in the first cycle after arst_n deassertion.

Structure
REQ-033 rom_pc_t and the FSM state enum fa_state_t SHALL reside in the shared eng pipe package, consumed also by XA.
REQ-034 Step counter with saturation and limit compare SHALL be sub-module eng_pipe_fa_wdog (inputs clr, inc; output at_max).

Verification
REQ-035 Cmd pc=0x10, no stall, done after 4th PC -> o_fa_pc_r 0x10,0x11,0x12,0x13, then vld=0, busy=0, rdy=1.
REQ-036 Cmd pc=0x20, stall 3 cycles after first issue -> o_fa_pc_r holds 0x20 for 4 cycles, then 0x21.
REQ-037 Cmd pc=0x30, redirect to 0x80 coincident with stall -> next o_fa_pc_r=0x80, vld=1.
REQ-038 Cmd pc=0xFE, no done -> 0xFE,0xFF, then o_err_r one-cycle pulse, vld=0, back to IDLE.
REQ-039 STEP_MAX=4, cmd pc=0x00, redirects to 0x00 forever -> 4 issues, then ABORT pulse, IDLE.
REQ-040 arst_n low mid-RUN at pc 0x45 -> outputs zero asynchronously, no err; new cmd accepted first cycle after release.
